// File: rtl/hex_rate_sequencer_if.sv
// Command and status bundle between the switch/key front end and the hex rate sequencer.
// The front end is the master; the sequencer is the slave.
interface hex_rate_sequencer_if;
    logic       start;
    logic       stop;
    logic       step;
    logic       clear;
    logic [1:0] speed;
    logic       wrap_en;
    logic [3:0] count;
    logic       tick;
    logic [1:0] state;
    logic       done;

    modport master (
        output start, stop, step, clear, speed, wrap_en,
        input  count, tick, state, done
    );

    modport slave (
        input  start, stop, step, clear, speed, wrap_en,
        output count, tick, state, done
    );
endinterface

// File: rtl/hex_rate_sequencer.sv
// Rate divider plus run/pause/step/terminal-count sequencing for the 4-bit hex count.
// state | meaning
// IDLE  | stopped, count cleared or stepped manually
// RUN   | divider counting down, one advance per interval
// PAUSE | divider frozen, step allowed
// DONE  | count reached 15 with wrap disabled, waiting for start
module hex_rate_sequencer #(
    parameter int TICK_BASE = 50000000
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    hex_rate_sequencer_if.slave  seq
);
    localparam int DIV_W = $clog2(4 * TICK_BASE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    state_t             state_r, state_nxt;
    logic [3:0]         count_r, count_nxt;
    logic [DIV_W-1:0]   div_r, div_nxt;
    logic               tick_r, tick_nxt;
    logic [1:0]         spd_r, spd_nxt;

    logic               do_start, do_step;
    logic               at_end;
    logic [3:0]         count_adv;

    // Interval P minus one, so a terminal count of zero marks the last cycle.
    function automatic logic [DIV_W-1:0] reload_of(input logic [1:0] spd);
        case (spd)
            2'b00:   reload_of = '0;
            2'b01:   reload_of = DIV_W'(TICK_BASE - 1);
            2'b10:   reload_of = DIV_W'(2 * TICK_BASE - 1);
            default: reload_of = DIV_W'(4 * TICK_BASE - 1);
        endcase
    endfunction

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r <= ST_IDLE;
            count_r <= 4'd0;
            div_r   <= '0;
            tick_r  <= 1'b0;
            spd_r   <= 2'b00;
        end else begin
            state_r <= state_nxt;
            count_r <= count_nxt;
            div_r   <= div_nxt;
            tick_r  <= tick_nxt;
            spd_r   <= spd_nxt;
        end
    end

    assign do_start  = seq.start && !seq.stop;
    assign do_step   = seq.step && !seq.stop && !seq.start;
    assign at_end    = (count_r == 4'hF) && !seq.wrap_en;
    assign count_adv = at_end ? 4'hF : count_r + 4'd1;

    always_comb begin
        state_nxt = state_r;
        count_nxt = count_r;
        div_nxt   = div_r;
        tick_nxt  = 1'b0;
        spd_nxt   = spd_r;
        if (seq.clear) begin
            state_nxt = ST_IDLE;
            count_nxt = 4'd0;
            div_nxt   = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (do_start) begin
                        state_nxt = ST_RUN;
                        spd_nxt   = seq.speed;
                        div_nxt   = reload_of(seq.speed);
                    end else if (do_step) begin
                        tick_nxt  = 1'b1;
                        count_nxt = count_adv;
                        if (at_end) state_nxt = ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (div_r != '0) begin
                        if (!seq.stop) div_nxt = div_r - DIV_W'(1);
                    end else begin
                        tick_nxt  = 1'b1;
                        count_nxt = count_adv;
                        spd_nxt   = seq.speed;
                        div_nxt   = reload_of(seq.speed);
                    end
                    // Reaching the end outranks a simultaneous pause request.
                    if (div_r == '0 && at_end) state_nxt = ST_DONE;
                    else if (seq.stop)         state_nxt = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (do_start) begin
                        state_nxt = ST_RUN;
                    end else if (do_step) begin
                        tick_nxt  = 1'b1;
                        count_nxt = count_adv;
                        if (at_end) state_nxt = ST_DONE;
                    end
                end
                default: begin
                    if (do_start) begin
                        state_nxt = ST_RUN;
                        count_nxt = 4'd0;
                        spd_nxt   = seq.speed;
                        div_nxt   = reload_of(seq.speed);
                    end
                end
            endcase
        end
    end

    always_comb begin
        seq.count = count_r;
        seq.tick  = tick_r;
        seq.state = state_r;
        seq.done  = (state_r == ST_DONE);
    end
endmodule

// File: tb/tb_hex_rate_sequencer.sv
// Directed bench for hex_rate_sequencer at TICK_BASE=4 (intervals 1, 4, 8, 16 cycles).
module tb_hex_rate_sequencer;
    logic CLOCK_50 = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    hex_rate_sequencer_if sif();

    hex_rate_sequencer #(.TICK_BASE(4)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .seq      (sif)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check_status(input string tag, input int st, input int cnt, input int tk, input int dn);
        check_eq({tag, "_state"}, sif.state, st);
        check_eq({tag, "_count"}, sif.count, cnt);
        check_eq({tag, "_tick"},  sif.tick,  tk);
        check_eq({tag, "_done"},  sif.done,  dn);
    endtask

    // gap-1 quiet cycles, then a tick carrying the given count.
    task automatic wait_tick(input string tag, input int gap, input int cnt);
        for (int i = 1; i < gap; i++) begin
            cyc();
            check_eq({tag, "_quiet"}, sif.tick, 0);
        end
        cyc();
        check_eq({tag, "_tick"}, sif.tick, 1);
        check_eq({tag, "_cnt"},  sif.count, cnt);
    endtask

    task automatic pulse_start();
        sif.start = 1'b1; cyc(); sif.start = 1'b0;
    endtask

    task automatic pulse_clear();
        sif.clear = 1'b1; cyc(); sif.clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        sif.start = 1'b0; sif.stop = 1'b0; sif.step = 1'b0; sif.clear = 1'b0;
        sif.speed = 2'b00; sif.wrap_en = 1'b0;
        cyc(); cyc();
        check_status("reset", 0, 0, 0, 0);
        reset = 1'b0;
        cyc();
        check_status("idle_hold", 0, 0, 0, 0);

        // basic run, P=4
        sif.speed = 2'b01;
        pulse_start();
        check_status("run_entry", 1, 0, 0, 0);
        wait_tick("run1", 4, 1);
        wait_tick("run2", 4, 2);
        wait_tick("run3", 4, 3);
        check_eq("run_state", sif.state, 1);

        // speed change two cycles after a tick: current interval keeps 4
        cyc(); check_eq("spd_q1", sif.tick, 0);
        cyc(); check_eq("spd_q2", sif.tick, 0);
        sif.speed = 2'b11;
        wait_tick("spd_old", 2, 4);
        wait_tick("spd_new1", 16, 5);
        wait_tick("spd_new2", 16, 6);

        // pause with divider 2 at count 3, then resume
        pulse_clear();
        check_status("clr1", 0, 0, 0, 0);
        sif.speed = 2'b01;
        pulse_start();
        wait_tick("pr1", 4, 1);
        wait_tick("pr2", 4, 2);
        wait_tick("pr3", 4, 3);
        cyc();
        sif.stop = 1'b1; cyc(); sif.stop = 1'b0;
        check_status("paused", 2, 3, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc();
            check_eq("pause_quiet", sif.tick, 0);
        end
        check_status("pause_hold", 2, 3, 0, 0);
        pulse_start();
        check_status("resume", 1, 3, 0, 0);
        wait_tick("resume_tick", 3, 4);

        // stop and start together: stop wins
        sif.stop = 1'b1; sif.start = 1'b1; cyc(); sif.stop = 1'b0; sif.start = 1'b0;
        check_eq("stop_wins", sif.state, 2);
        sif.step = 1'b1; cyc(); sif.step = 1'b0;
        check_status("pause_step", 2, 5, 1, 0);

        // interval P=8
        pulse_clear();
        sif.speed = 2'b10;
        pulse_start();
        wait_tick("p8", 8, 1);

        // terminal count without wrap
        pulse_clear();
        sif.speed = 2'b00; sif.wrap_en = 1'b0;
        pulse_start();
        check_status("term_entry", 1, 0, 0, 0);
        for (int i = 1; i <= 15; i++) begin
            cyc();
            check_eq("term_tick", sif.tick, 1);
            check_eq("term_cnt",  sif.count, i);
            check_eq("term_run",  sif.state, 1);
        end
        cyc();
        check_status("term_done", 3, 15, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_status("done_quiet", 3, 15, 0, 1);
        end
        sif.step = 1'b1; cyc(); sif.step = 1'b0;
        check_status("done_step", 3, 15, 0, 1);
        pulse_start();
        check_status("done_restart", 1, 0, 0, 0);
        cyc();
        check_status("restart_tick", 1, 1, 1, 0);

        // wrap enabled
        pulse_clear();
        sif.wrap_en = 1'b1;
        pulse_start();
        for (int i = 1; i <= 16; i++) begin
            cyc();
            check_eq("wrap_tick", sif.tick, 1);
            check_eq("wrap_cnt",  sif.count, i % 16);
        end
        check_status("wrap_zero", 1, 0, 1, 0);
        cyc();
        check_status("wrap_more", 1, 1, 1, 0);

        // step in IDLE
        pulse_clear();
        check_status("clr2", 0, 0, 0, 0);
        sif.step = 1'b1; cyc(); sif.step = 1'b0;
        check_status("idle_step", 0, 1, 1, 0);
        cyc();
        check_status("idle_step_after", 0, 1, 0, 0);

        // clear mid-run at count 7
        pulse_clear();
        pulse_start();
        for (int i = 1; i <= 7; i++) cyc();
        check_eq("pre_clear_cnt", sif.count, 7);
        pulse_clear();
        check_status("mid_clear", 0, 0, 0, 0);

        // reset together with start mid-run
        pulse_start();
        cyc(); cyc(); cyc();
        check_eq("pre_reset_cnt", sif.count, 3);
        reset = 1'b1; sif.start = 1'b1; cyc(); reset = 1'b0; sif.start = 1'b0;
        check_status("reset_start", 0, 0, 0, 0);
        cyc();
        check_status("post_reset", 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
